// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// oversampling clock divisor used by both uart_rx and uart_tx.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } uart_state_e;

   // Clocks per oversample tick, truncated (27 for 50 MHz / 115200 / 16).
   function automatic int calc_divisor(input int clk_freq,
                                       input int baud_rate,
                                       input int oversample);
      return clk_freq / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIVISOR clocks;
// a synchronous restart realigns the phase to the caller's event.
module uart_baud_tick #(
   parameter int DIVISOR = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (restart || (cnt == CNT_LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = !restart && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, start-glitch rejection,
// three-sample majority vote per bit and stop-bit framing check.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_error,
   output logic                 rx_busy
);

   localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam int BW      = $clog2(DATA_BITS);

   // The sample counter is restarted at the start-bit centre, so each later
   // bit centre falls on its last count; the vote uses the two ticks before it.
   localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_EARLY = SW'(OVERSAMPLE - 3);
   localparam logic [SW-1:0] S_LATE  = SW'(OVERSAMPLE - 2);
   localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

   logic                 rx_meta;
   logic                 rx_sync;
   logic                 tick;
   logic                 restart;
   logic                 vote;

   uart_state_e          state;
   uart_state_e          state_next;
   logic [SW-1:0]        s_cnt;
   logic [SW-1:0]        s_cnt_next;
   logic [BW-1:0]        bit_idx;
   logic [BW-1:0]        bit_idx_next;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_next;
   logic [1:0]           samp;
   logic [1:0]           samp_next;
   logic                 valid_next;
   logic                 ferr_next;

   // Synchronizer flops reset to the idle line level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   uart_baud_tick #(
      .DIVISOR (DIVISOR)
   ) u_baud_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   assign vote = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);

   always_comb begin
      state_next   = state;
      s_cnt_next   = s_cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift_reg;
      samp_next    = samp;
      restart      = 1'b0;
      valid_next   = 1'b0;
      ferr_next    = 1'b0;

      if (((state == DATA) || (state == STOP)) && tick) begin
         if (s_cnt == S_EARLY) samp_next[0] = rx_sync;
         if (s_cnt == S_LATE)  samp_next[1] = rx_sync;
      end

      case (state)
         IDLE: begin
            // Holding the divider in restart aligns tick phase to the edge.
            restart = 1'b1;
            if (!rx_sync) begin
               state_next   = START;
               s_cnt_next   = '0;
               bit_idx_next = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_cnt == S_MID) begin
                  s_cnt_next   = '0;
                  bit_idx_next = '0;
                  state_next   = rx_sync ? IDLE : DATA;
               end else begin
                  s_cnt_next = s_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_cnt == S_LAST) begin
                  shift_next = {vote, shift_reg[DATA_BITS-1:1]};
                  s_cnt_next = '0;
                  if (bit_idx == B_LAST) begin
                     state_next = STOP;
                  end else begin
                     bit_idx_next = bit_idx + 1'b1;
                  end
               end else begin
                  s_cnt_next = s_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_cnt == S_LAST) begin
                  s_cnt_next = '0;
                  if (vote) begin
                     valid_next = 1'b1;
                     state_next = IDLE;
                  end else begin
                     ferr_next  = 1'b1;
                     state_next = WAIT_IDLE;
                  end
               end else begin
                  s_cnt_next = s_cnt + 1'b1;
               end
            end
         end
         WAIT_IDLE: begin
            // A break or stuck-low line must release before a new frame.
            if (rx_sync) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         s_cnt     <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         samp      <= '0;
      end else begin
         state     <= state_next;
         s_cnt     <= s_cnt_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
         samp      <= samp_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         if (valid_next) data_out <= shift_reg;
         data_valid  <= valid_next;
         frame_error <= ferr_next;
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven at nominal and skewed
// baud rates, glitches, framing errors and a mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_error;
   logic       rx_busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int n_ferr   = 0;
   logic prev_dv = 1'b0;
   logic prev_fe = 1'b0;
   logic [7:0] exp_q[$];

   localparam int BIT_NS = 8640;

   uart_rx dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_error (frame_error),
      .rx_busy     (rx_busy)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // driver tasks
   task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_bit);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      rx = stop_bit;
      #(bit_ns);
   endtask

   task automatic wait_idle(input int max_ns);
      int t = 0;
      while ((rx_busy || exp_q.size() != 0) && t < max_ns) begin
         #20;
         t += 20;
      end
      check("drain_queue", exp_q.size(), 0);
      check("drain_busy", rx_busy, 0);
   endtask

   // scoreboard / monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         if (prev_dv) check("dv_one_cycle", data_valid, 0);
         if (prev_fe) check("fe_one_cycle", frame_error, 0);
         if (data_valid) begin
            n_valid++;
            check("dv_fe_exclusive", frame_error, 0);
            if (exp_q.size() == 0) check("exp_q_size", exp_q.size(), 1);
            else check("rx_byte", data_out, exp_q.pop_front());
         end
         if (frame_error) n_ferr++;
      end
      prev_dv <= data_valid;
      prev_fe <= frame_error;
   end

   initial begin
      int v0;
      int f0;
      reset = 1'b0;
      rx    = 1'b1;
      #5;
      #100;
      check("rst_data_out", data_out, 8'h00);
      check("rst_data_valid", data_valid, 0);
      check("rst_frame_error", frame_error, 0);
      check("rst_busy", rx_busy, 0);
      #100;
      reset = 1'b1;
      #200;

      // single byte
      v0 = n_valid;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, BIT_NS, 1'b1);
      wait_idle(4 * BIT_NS);
      check("a5_count", n_valid - v0, 1);
      check("a5_data", data_out, 8'hA5);
      check("a5_no_fe", n_ferr, 0);

      // back-to-back
      v0 = n_valid;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_byte(8'h3C, BIT_NS, 1'b1);
      send_byte(8'h00, BIT_NS, 1'b1);
      send_byte(8'hFF, BIT_NS, 1'b1);
      wait_idle(4 * BIT_NS);
      check("b2b_count", n_valid - v0, 3);
      check("b2b_last", data_out, 8'hFF);

      // start glitch
      v0 = n_valid;
      f0 = n_ferr;
      rx = 1'b0;
      #1000;
      check("glitch_busy", rx_busy, 1);
      #2000;
      rx = 1'b1;
      #2000;
      check("glitch_busy_clear", rx_busy, 0);
      check("glitch_no_dv", n_valid - v0, 0);
      check("glitch_no_fe", n_ferr - f0, 0);

      // framing error with the line held low for a while afterwards
      v0 = n_valid;
      f0 = n_ferr;
      send_byte(8'h55, BIT_NS, 1'b0);
      #(10 * BIT_NS);
      check("fe_count", n_ferr - f0, 1);
      check("fe_no_dv", n_valid - v0, 0);
      check("fe_data_kept", data_out, 8'hFF);
      check("fe_busy_held", rx_busy, 1);
      rx = 1'b1;
      #200;
      check("fe_released", rx_busy, 0);
      exp_q.push_back(8'h81);
      send_byte(8'h81, BIT_NS, 1'b1);
      wait_idle(4 * BIT_NS);
      check("after_fe_data", data_out, 8'h81);

      // baud skew of -3% and +3%
      v0 = n_valid;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 8380, 1'b1);
      wait_idle(4 * BIT_NS);
      check("fast_data", data_out, 8'hA5);
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 8900, 1'b1);
      wait_idle(4 * BIT_NS);
      check("slow_data", data_out, 8'h5A);
      check("skew_count", n_valid - v0, 2);

      // reset pulse in bit 4 of 8'hC3
      v0 = n_valid;
      fork
         send_byte(8'hC3, BIT_NS, 1'b1);
         begin
            #(5 * BIT_NS + 200);
            reset = 1'b0;
            #40;
            check("mid_rst_data", data_out, 8'h00);
            check("mid_rst_dv", data_valid, 0);
            check("mid_rst_fe", frame_error, 0);
            check("mid_rst_busy", rx_busy, 0);
            #60;
            reset = 1'b1;
            // The line is low at release, so a new frame starts there; it
            // sees bits 5..7 of C3 (0,1,1), the stop bit and idle: 8'hFE.
            exp_q.push_back(8'hFE);
         end
      join
      check("mid_rst_no_pulse", n_valid - v0, 0);
      wait_idle(12 * BIT_NS);
      check("mid_rst_phantom", data_out, 8'hFE);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, BIT_NS, 1'b1);
      wait_idle(4 * BIT_NS);
      check("post_rst_data", data_out, 8'h3C);
      check("post_rst_count", n_valid - v0, 2);

      // final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
